// File: rtl/synth_pkg.sv
// Shared types and constants for the envelope/VCA voice path.
// Exports: AUDIO_W, ENV_W, ENV_MAX, adsr_state_t.
package synth_pkg;

    localparam int AUDIO_W = 24;
    localparam int ENV_W   = 16;

    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

endpackage

// File: rtl/envelope_vca_if.sv
// Output sample stream of the envelope/VCA stage.
// val_out: scaled sample, valid_out: one-cycle strobe per new sample.
interface envelope_vca_if;
    import synth_pkg::*;

    logic [AUDIO_W-1:0] val_out;
    logic               valid_out;

    modport master (
        output val_out,
        output valid_out
    );

    modport slave (
        input val_out,
        input valid_out
    );

endinterface

// File: rtl/adsr_core.sv
// ADSR state machine and envelope level register, stepped on tick.
// In: clk, rst_n, tick, gate, rates, sustain. Out: level, state.
module adsr_core
    import synth_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_rate,
    input  logic [ENV_W-1:0] decay_rate,
    input  logic [ENV_W-1:0] release_rate,
    input  logic [ENV_W-1:0] sustain,
    output logic [ENV_W-1:0] level,
    output adsr_state_t      state
);

    logic [ENV_W:0]        att_sum;
    logic                  att_full;
    logic signed [ENV_W:0] dec_diff;
    logic                  dec_done;
    logic                  rel_zero;
    logic [ENV_W-1:0]      rel_level;

    // 17-bit sum so overflow past full scale is visible
    assign att_sum  = {1'b0, level} + {1'b0, attack_rate};
    assign att_full = (attack_rate == '0) || att_sum[ENV_W]
                    || (att_sum[ENV_W-1:0] == ENV_MAX);

    // signed difference so an undershoot below zero still
    // compares as below sustain
    assign dec_diff = $signed({1'b0, level})
                    - $signed({1'b0, decay_rate});
    assign dec_done = (decay_rate == '0)
                    || (dec_diff <= $signed({1'b0, sustain}));

    assign rel_zero  = (release_rate == '0) || (level <= release_rate);
    assign rel_level = level - release_rate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= '0;
        end else if (tick) begin
            // gate changes win over level-driven transitions
            if (!gate && state != IDLE) begin
                if (rel_zero) begin
                    state <= IDLE;
                    level <= '0;
                end else begin
                    state <= RELEASE;
                    level <= rel_level;
                end
            end else begin
                unique case (state)
                    IDLE, ATTACK, RELEASE: begin
                        if (!gate) begin
                            state <= IDLE;
                            level <= '0;
                        end else if (att_full) begin
                            state <= DECAY;
                            level <= ENV_MAX;
                        end else begin
                            state <= ATTACK;
                            level <= att_sum[ENV_W-1:0];
                        end
                    end
                    DECAY: begin
                        if (dec_done) begin
                            state <= SUSTAIN;
                            level <= sustain;
                        end else begin
                            level <= dec_diff[ENV_W-1:0];
                        end
                    end
                    SUSTAIN: level <= sustain;
                    default: begin
                        state <= IDLE;
                        level <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/envelope_vca.sv
// ADSR envelope generator feeding a pipelined VCA multiplier.
// In: clk_in, rst_n_in, sample_tick_in, gate_in, audio_in, rates,
// sustain. Out: env_out, busy_out, out_if (val_out, valid_out).
module envelope_vca
    import synth_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               sample_tick_in,
    input  logic               gate_in,
    input  logic [AUDIO_W-1:0] audio_in,
    input  logic [ENV_W-1:0]   attack_rate_in,
    input  logic [ENV_W-1:0]   decay_rate_in,
    input  logic [ENV_W-1:0]   release_rate_in,
    input  logic [ENV_W-1:0]   sustain_level_in,
    output logic [ENV_W-1:0]   env_out,
    output logic               busy_out,
    envelope_vca_if.master     out_if
);

    localparam int PROD_W = AUDIO_W + ENV_W;

    adsr_state_t               state;
    logic [ENV_W-1:0]          level;
    logic signed [AUDIO_W-1:0] audio_q;
    logic signed [PROD_W-1:0]  product;
    logic                      v0;
    logic                      v1;

    adsr_core u_core (
        .clk          (clk_in),
        .rst_n        (rst_n_in),
        .tick         (sample_tick_in),
        .gate         (gate_in),
        .attack_rate  (attack_rate_in),
        .decay_rate   (decay_rate_in),
        .release_rate (release_rate_in),
        .sustain      (sustain_level_in),
        .level        (level),
        .state        (state)
    );

    assign env_out  = level;
    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            audio_q          <= '0;
            product          <= '0;
            v0               <= 1'b0;
            v1               <= 1'b0;
            out_if.val_out   <= '0;
            out_if.valid_out <= 1'b0;
        end else begin
            if (sample_tick_in)
                audio_q <= audio_in;
            v0 <= sample_tick_in;
            // level < 2^16 keeps the signed product inside PROD_W bits,
            // so the top (41st) bit of the full product is redundant
            product <= PROD_W'(audio_q * $signed({1'b0, level}));
            v1 <= v0;
            out_if.val_out   <= product[PROD_W-1:ENV_W];
            out_if.valid_out <= v1;
        end
    end

endmodule

// File: doc/envelope_vca.md
# envelope_vca

ADSR envelope generator plus voltage-controlled amplifier, directly downstream of the `triangle` oscillator. It takes the oscillator's signed 24-bit sample stream and shapes it with a gate-driven attack/decay/sustain/release envelope. It emits the scaled sample with a valid strobe for the mixer/output stage. The envelope advances only on the audio sample tick; the multiply path is fully pipelined.

## Interface
- `AUDIO_W`, 24: sample width, two's complement.
- `ENV_W`, 16: envelope level width, unsigned; full scale is `2^ENV_W-1`.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset, asynchronous and active-low.
- `sample_tick_in` input 1: one-cycle strobe, one per audio sample; back-to-back ticks are legal.
- `gate_in` input 1: note on (1) / off (0); sampled only on tick cycles.
- `audio_in` input AUDIO_W: oscillator sample (`triangle.val_out`); sampled on tick cycles.
- `attack_rate_in`, `decay_rate_in`, `release_rate_in` input ENV_W each: level step per tick; 0 = instantaneous.
- `sustain_level_in` input ENV_W: sustain level.
- `val_out` output AUDIO_W: scaled sample.
- `valid_out` output 1: one-cycle pulse marking a new `val_out`.
- `env_out` output ENV_W: current envelope level.
- `busy_out` output 1: high when state ≠ IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. State and level update only on cycles with `sample_tick_in`=1; otherwise both hold.
- IDLE: level = 0. gate=1 → ATTACK, with this tick's step applied.
- ATTACK: level += attack_rate, computed 17-bit, saturating at ENV_MAX. On reaching ENV_MAX (or rate 0) → DECAY at ENV_MAX. gate=0 → RELEASE; the release step applies on that same tick.
- DECAY: if level − decay_rate ≤ sustain (17-bit signed compare), or rate 0, level = sustain and → SUSTAIN. Otherwise level −= decay_rate. gate=0 → RELEASE.
- SUSTAIN: level = `sustain_level_in` every tick, so it tracks live changes. gate=0 → RELEASE.
- RELEASE: level −= release_rate, floored at 0. Reaching 0 (or rate 0) → IDLE. gate=1 → ATTACK from the current level (retrigger, no reset to 0).
- Gate priority: a gate change overrides any pending level-driven transition on the same tick.
- VCA: product = `audio_q` × {1'b0, level}, 41-bit signed. `val_out` = product[ENV_W+AUDIO_W-1 : ENV_W], i.e. an arithmetic shift right by ENV_W (floor).
  - Full scale is 65535/65536 gain, not unity; no saturation is possible.

## Timing
- Reset values: state IDLE, level 0, `audio_q` 0, product 0, `val_out` 0, `valid_out` 0, `env_out` 0, `busy_out` 0.
- Edge E0 (tick high): state, level and `audio_q` update. `env_out` and `busy_out` reflect the new values after E0.
- E1: product register loads `audio_q` × level.
- E2: `val_out` loads; `valid_out` is high for exactly the cycle after E2.
- Total latency is 2 cycles from the tick edge, one result per tick. Sustained throughput is 1 per clock.
- An async reset mid-operation clears everything immediately. No `valid_out` pulse emerges from in-flight samples.
- Rate and sustain inputs are sampled on tick cycles only; changes between ticks have no effect until the next tick.

## Structure
- Package `synth_pkg` holds:
  - `adsr_state_t` enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE)
  - `AUDIO_W`, `ENV_W`
  - `ENV_MAX`
- Sub-module `adsr_core`: contains the FSM and level register, with inputs tick, gate, rates and sustain, and outputs level and state.
- The `envelope_vca` top contains `adsr_core`, the `audio_q` register, the product pipeline and the output register.

## Test plan
- Reset: assert `rst_n_in`=0 mid-stream → all outputs 0 immediately with no clock needed; on release, state is IDLE.
- Attack: attack_rate=0x4000, gate=1, 4 ticks → `env_out` 0x4000, 0x8000, 0xC000, 0xFFFF; state goes to DECAY after the 4th tick.
- Decay: decay_rate=0x1000, sustain=0xC000 from 0xFFFF → 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000 with state SUSTAIN.
  - Changing sustain to 0x8000 → `env_out`=0x8000 on the next tick.
- Release/retrigger: release_rate=0x2000 from 0x8000, gate=0 → 0x6000, 0x4000. Then gate=1 with attack 0x4000 → 0x8000 (no drop to 0). Separately, release to 0 → IDLE and `busy_out`=0.
- VCA math: level held at 0xFFFF.
  - `audio_in`=0x400000 → `val_out`=0x3FFFC0, 2 cycles after the tick, with a single `valid_out` pulse.
  - `audio_in`=0xC00000 (−0x400000) → `val_out`=0xC00040.
  - At level 0 → `val_out`=0.
- Back-to-back ticks: tick every cycle for 8 cycles → 8 consecutive `valid_out` pulses, in order, with no bubbles.
- Instant rates: all rates 0.
  - gate=1 → ENV_MAX after 1 tick, then sustain on the next tick.
  - gate=0 → 0 and IDLE in 1 tick.
